// File: rtl/gain_swap_sequencer_if.sv
// Command bus of the gain/swap sequencer: valid/ready handshake carrying an
// opcode and a gain word.
interface gain_swap_sequencer_if #(
  parameter int data_width = 16
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [data_width-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/gain_swap_sequencer.sv
// Sequences click-free gain ramps and pipeline swaps for a downstream mixer,
// one command at a time, paced by the sample tick.
module gain_swap_sequencer #(
  parameter int data_width    = 16,
  parameter int gain_shift    = 4,
  parameter int step_shift    = 6,
  parameter int timeout_ticks = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  gain_swap_sequencer_if.slave  cmd_if,
  input  logic                  sample_tick_i,
  output logic [data_width-1:0] gain_data_o,
  output logic                  set_input_gain_o,
  output logic                  set_output_gain_o,
  output logic                  swap_pipelines_o,
  input  logic                  pipelines_swapping_i,
  output logic                  busy_o,
  output logic                  cmd_error_o,
  output logic                  swap_timeout_o
);

  localparam logic [data_width-1:0] unity =
    {{(data_width-1){1'b0}}, 1'b1} << (data_width - 1 - gain_shift);
  localparam logic [data_width-1:0] step = unity >> step_shift;
  localparam int                    cnt_width = $clog2(timeout_ticks + 1);
  localparam logic [cnt_width-1:0]  timeout_cnt = cnt_width'(timeout_ticks);

  typedef enum logic [2:0] {
    IDLE,
    RAMP_IN,
    RAMP_OUT,
    SWAP_REQ,
    SWAP_WAIT
  } state_t;

  state_t                state_q, state_d;
  logic [data_width-1:0] target_q, target_d;
  logic [data_width-1:0] in_gain_q, in_gain_d;
  logic [data_width-1:0] out_gain_q, out_gain_d;
  logic [data_width-1:0] gain_data_q, gain_data_d;
  logic                  set_in_q, set_in_d;
  logic                  set_out_q, set_out_d;
  logic                  swap_q, swap_d;
  logic                  cmd_error_q, cmd_error_d;
  logic                  timeout_q, timeout_d;
  logic                  seen_high_q, seen_high_d;
  logic [cnt_width-1:0]  tick_cnt_q, tick_cnt_d;

  logic [data_width-1:0] cur_gain;
  logic [data_width-1:0] gain_diff;
  logic [data_width-1:0] ramp_next;
  logic [cnt_width-1:0]  cnt_inc;

  // One ramp step: compare the distance first so the add/subtract never wraps.
  always_comb begin
    cur_gain  = (state_q == RAMP_OUT) ? out_gain_q : in_gain_q;
    gain_diff = '0;
    ramp_next = cur_gain;
    if (target_q > cur_gain) begin
      gain_diff = target_q - cur_gain;
      ramp_next = (gain_diff <= step) ? target_q : cur_gain + step;
    end else begin
      gain_diff = cur_gain - target_q;
      ramp_next = (gain_diff <= step) ? target_q : cur_gain - step;
    end
  end

  assign cnt_inc = tick_cnt_q + cnt_width'(1);

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    in_gain_d   = in_gain_q;
    out_gain_d  = out_gain_q;
    gain_data_d = gain_data_q;
    set_in_d    = 1'b0;
    set_out_d   = 1'b0;
    swap_d      = 1'b0;
    cmd_error_d = cmd_error_q;
    timeout_d   = timeout_q;
    seen_high_d = seen_high_q;
    tick_cnt_d  = tick_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_if.cmd_valid) begin
          case (cmd_if.cmd_op)
            2'd0: begin
              target_d = cmd_if.cmd_data;
              state_d  = RAMP_IN;
            end
            2'd1: begin
              target_d = cmd_if.cmd_data;
              state_d  = RAMP_OUT;
            end
            2'd2:    state_d = SWAP_REQ;
            default: cmd_error_d = 1'b1;
          endcase
        end
      end

      RAMP_IN, RAMP_OUT: begin
        if (sample_tick_i) begin
          if (cur_gain == target_q) begin
            state_d = IDLE;
          end else begin
            gain_data_d = ramp_next;
            if (state_q == RAMP_IN) begin
              in_gain_d = ramp_next;
              set_in_d  = 1'b1;
            end else begin
              out_gain_d = ramp_next;
              set_out_d  = 1'b1;
            end
          end
        end
      end

      SWAP_REQ: begin
        swap_d      = 1'b1;
        seen_high_d = 1'b0;
        tick_cnt_d  = '0;
        state_d     = SWAP_WAIT;
      end

      SWAP_WAIT: begin
        if (pipelines_swapping_i) seen_high_d = 1'b1;
        if (sample_tick_i) tick_cnt_d = cnt_inc;
        // A crossfade that finishes on the timeout tick still counts as done.
        if (!pipelines_swapping_i && seen_high_q) begin
          state_d = IDLE;
        end else if (sample_tick_i && (cnt_inc == timeout_cnt)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= '0;
      in_gain_q   <= unity;
      out_gain_q  <= unity;
      gain_data_q <= '0;
      set_in_q    <= 1'b0;
      set_out_q   <= 1'b0;
      swap_q      <= 1'b0;
      cmd_error_q <= 1'b0;
      timeout_q   <= 1'b0;
      seen_high_q <= 1'b0;
      tick_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      in_gain_q   <= in_gain_d;
      out_gain_q  <= out_gain_d;
      gain_data_q <= gain_data_d;
      set_in_q    <= set_in_d;
      set_out_q   <= set_out_d;
      swap_q      <= swap_d;
      cmd_error_q <= cmd_error_d;
      timeout_q   <= timeout_d;
      seen_high_q <= seen_high_d;
      tick_cnt_q  <= tick_cnt_d;
    end
  end

  assign cmd_if.cmd_ready  = (state_q == IDLE);
  assign busy_o            = (state_q != IDLE);
  assign gain_data_o       = gain_data_q;
  assign set_input_gain_o  = set_in_q;
  assign set_output_gain_o = set_out_q;
  assign swap_pipelines_o  = swap_q;
  assign cmd_error_o       = cmd_error_q;
  assign swap_timeout_o    = timeout_q;

endmodule

// File: tb/tb_gain_swap_sequencer.sv
// Randomized bench for gain_swap_sequencer: ramps are predicted in closed form
// (k-th strobe = cur +/- k*step, clamped at target) and swaps by a small mixer model.
module tb_gain_swap_sequencer;
  localparam int DW    = 16;
  localparam int UNITY = 2048;
  localparam int STEP  = 32;
  localparam int TMO   = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_tick = 1'b0;
  logic          pipelines_swapping = 1'b0;
  logic [DW-1:0] gain_data;
  logic          set_in, set_out, swap_p, busy, cmd_error, swap_timeout;

  always #5 clk = ~clk;

  gain_swap_sequencer_if #(.data_width(DW)) cmd_if ();

  gain_swap_sequencer #(
    .data_width(DW), .gain_shift(4), .step_shift(6), .timeout_ticks(TMO)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd_if              (cmd_if),
    .sample_tick_i       (sample_tick),
    .gain_data_o         (gain_data),
    .set_input_gain_o    (set_in),
    .set_output_gain_o   (set_out),
    .swap_pipelines_o    (swap_p),
    .pipelines_swapping_i(pipelines_swapping),
    .busy_o              (busy),
    .cmd_error_o         (cmd_error),
    .swap_timeout_o      (swap_timeout)
  );

  int checks = 0;
  int errors = 0;
  int in_obs[$];
  int out_obs[$];
  int swap_cnt = 0;
  int excl_cnt = 0;

  // Reference state: current gains, last value shown on gain_data, sticky flags.
  int m_in, m_out, m_gd;
  int m_err, m_to;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (set_in) in_obs.push_back(int'(gain_data));
    if (set_out) out_obs.push_back(int'(gain_data));
    if (swap_p) swap_cnt++;
    if ((set_in && set_out) || (set_in && swap_p) || (set_out && swap_p)) excl_cnt++;
  end

  task automatic cycle(input int tick_den);
    sample_tick = ($urandom_range(0, tick_den - 1) == 0);
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    sample_tick = 1'b0;
    pipelines_swapping = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_cmd_ready", cmd_if.cmd_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_gain_data", gain_data, 0);
    check_val("rst_strobes", {set_in, set_out, swap_p}, 0);
    check_val("rst_flags", {cmd_error, swap_timeout}, 0);
    reset = 1'b0;
    m_in = UNITY; m_out = UNITY; m_gd = 0; m_err = 0; m_to = 0;
    $display("txn reset");
  endtask

  // Accepted on the next edge; a random tick rides along and must be ignored.
  task automatic send_cmd(input int op, input int data);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'(op);
    cmd_if.cmd_data  = DW'(data);
    sample_tick      = ($urandom_range(0, 1) == 1);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    sample_tick      = 1'b0;
  endtask

  task automatic check_common();
    check_val("gain_data_hold", gain_data, m_gd);
    check_val("cmd_error_flag", cmd_error, m_err);
    check_val("swap_timeout_flag", swap_timeout, m_to);
    check_val("strobe_exclusive", excl_cnt, 0);
  endtask

  task automatic do_ramp(input int op, input int tgt);
    int cur, d, n, ticks, cyc, budget, v, done;
    int exp_q[$];
    cur = (op == 0) ? m_in : m_out;
    d = (tgt > cur) ? tgt - cur : cur - tgt;
    n = (d + STEP - 1) / STEP;
    for (int k = 1; k <= n; k++) begin
      if (tgt > cur) v = (cur + k * STEP < tgt) ? cur + k * STEP : tgt;
      else           v = (cur - k * STEP > tgt) ? cur - k * STEP : tgt;
      exp_q.push_back(v);
    end
    in_obs.delete(); out_obs.delete(); swap_cnt = 0;
    send_cmd(op, tgt);
    budget = (n + 1) * 12 + 100;
    ticks = 0; cyc = 0; done = 0;
    while (!done && cyc < budget) begin
      sample_tick = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      if (sample_tick) ticks++;
      cyc++;
      if (cmd_if.cmd_ready) done = 1;
    end
    sample_tick = 1'b0;
    check_val("ramp_done", done, 1);
    check_val("ramp_ticks", ticks, n + 1);
    if (op == 0) begin
      check_val("ramp_in_count", in_obs.size(), n);
      check_val("ramp_in_no_out", out_obs.size(), 0);
      for (int i = 0; i < n && i < in_obs.size(); i++) check_val("ramp_in_value", in_obs[i], exp_q[i]);
    end else begin
      check_val("ramp_out_count", out_obs.size(), n);
      check_val("ramp_out_no_in", in_obs.size(), 0);
      for (int i = 0; i < n && i < out_obs.size(); i++) check_val("ramp_out_value", out_obs[i], exp_q[i]);
    end
    check_val("ramp_no_swap", swap_cnt, 0);
    if (n > 0) begin
      if (op == 0) m_in = tgt; else m_out = tgt;
      m_gd = tgt;
    end
    check_common();
    $display("txn op=%0d from=%0d target=%0d strobes=%0d ticks=%0d", op, cur, tgt, n, ticks);
  endtask

  task automatic wait_swap_pulse();
    int got;
    got = 0;
    for (int i = 0; i < 8 && got == 0; i++) begin
      @(posedge clk);
      #1;
      if (swap_p) got = 1;
    end
    check_val("swap_pulse_seen", got, 1);
  endtask

  task automatic do_swap(input int dly, input int hi);
    in_obs.delete(); out_obs.delete(); swap_cnt = 0;
    send_cmd(2, int'($urandom_range(0, 65535)));
    wait_swap_pulse();
    repeat (dly) cycle(8);
    pipelines_swapping = 1'b1;
    repeat (hi) cycle(8);
    pipelines_swapping = 1'b0;
    check_val("swap_busy_before_fall", busy, 1);
    cycle(8);
    check_val("swap_busy_after_fall", busy, 0);
    repeat (3) cycle(8);
    check_val("swap_pulse_count", swap_cnt, 1);
    check_val("swap_no_gain_strobe", in_obs.size() + out_obs.size(), 0);
    check_common();
    $display("txn op=2 delay=%0d high=%0d pulses=%0d", dly, hi, swap_cnt);
  endtask

  task automatic do_illegal();
    in_obs.delete(); out_obs.delete(); swap_cnt = 0;
    send_cmd(3, int'($urandom_range(0, 65535)));
    m_err = 1;
    check_val("illegal_cmd_ready", cmd_if.cmd_ready, 1);
    repeat (5) cycle(2);
    check_val("illegal_cmd_ready_after", cmd_if.cmd_ready, 1);
    check_val("illegal_no_strobes", in_obs.size() + out_obs.size() + swap_cnt, 0);
    check_common();
    $display("txn op=3 cmd_error=%0d", cmd_error);
  endtask

  task automatic do_swap_timeout(input int complete_on_last);
    swap_cnt = 0;
    send_cmd(2, 0);
    wait_swap_pulse();
    pipelines_swapping = complete_on_last[0];
    sample_tick = 1'b1;
    repeat (TMO - 1) @(posedge clk);
    #1;
    check_val("tmo_busy_before_limit", busy, 1);
    pipelines_swapping = 1'b0;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    check_val("tmo_idle_at_limit", busy, 0);
    if (complete_on_last == 0) m_to = 1;
    repeat (3) cycle(2);
    check_val("tmo_pulse_count", swap_cnt, 1);
    check_common();
    $display("txn op=2 ticks=%0d completing=%0d swap_timeout=%0d", TMO, complete_on_last, swap_timeout);
  endtask

  task automatic do_reset_mid_ramp();
    int got;
    in_obs.delete(); out_obs.delete();
    send_cmd(0, 2144);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      sample_tick = 1'b1;
      @(posedge clk);
      #1;
      if (set_in) got = 1;
    end
    sample_tick = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("midrst_gain_data", gain_data, 0);
    reset = 1'b0;
    m_in = UNITY; m_out = UNITY; m_gd = 0; m_err = 0; m_to = 0;
    repeat (4) cycle(1);
    check_val("midrst_first_seen", got, 1);
    check_val("midrst_strobe_count", in_obs.size(), 1);
    if (in_obs.size() > 0) check_val("midrst_first_value", in_obs[0], 2080);
    check_val("midrst_idle", cmd_if.cmd_ready, 1);
    $display("txn reset mid-ramp strobes=%0d", in_obs.size());
    do_ramp(0, 2080);
  endtask

  initial begin
    int r, cur, tgt;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_data  = '0;
    do_reset();

    do_ramp(0, 2144);
    do_ramp(1, 2008);
    do_swap(3, 10);
    do_illegal();
    do_ramp(0, 2144);

    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 15));
      if (r < 14) begin
        cur = (r < 7) ? m_in : m_out;
        case ($urandom_range(0, 4))
          0:       tgt = cur;
          1:       tgt = int'($urandom_range(0, 8191));
          default: tgt = cur + int'($urandom_range(0, 400)) - 200;
        endcase
        if (tgt < 0) tgt = 0;
        if (tgt > 65535) tgt = 65535;
        do_ramp((r < 7) ? 0 : 1, tgt);
      end else if (r == 14) begin
        do_swap(int'($urandom_range(0, 5)), int'($urandom_range(1, 12)));
      end else begin
        do_illegal();
      end
    end

    do_ramp(1, 65535);
    do_ramp(1, 65535 - int'($urandom_range(1, 20)));
    do_ramp(1, 0);

    do_reset();
    do_reset_mid_ramp();
    do_swap_timeout(0);
    do_ramp(0, 2000);
    do_reset();
    do_swap_timeout(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
